// File: rtl/rrt_pkg.sv
// Shared types for the RRT sample generator: coordinate width, FSM states and a 2-D point.
package rrt_pkg;

    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        HOLD
    } state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

endpackage

// File: rtl/rrt_sampler.sv
// Draws random (x, y) samples from a PRNG word, biased toward a goal point, with rejection of
// out-of-bounds candidates and valid/ready output plus reject/sample statistics.
module rrt_sampler #(
    parameter int unsigned COORD_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [63:0]        rand_in,
    output logic               rand_en,
    input  logic [COORD_W-1:0] x_max,
    input  logic [COORD_W-1:0] y_max,
    input  logic [COORD_W-1:0] x_mask,
    input  logic [COORD_W-1:0] y_mask,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    input  logic [7:0]         goal_bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic               out_is_goal,
    input  logic               clear_stats,
    output logic [15:0]        reject_count,
    output logic [31:0]        sample_count
);
    import rrt_pkg::*;

    state_t             state_q, state_d;
    point_t             pt_q, pt_d;
    logic               goal_q, goal_d;
    logic [15:0]        rej_q, rej_d;
    logic [31:0]        cnt_q, cnt_d;

    logic [COORD_W-1:0] cand_x, cand_y;
    logic [7:0]         bias_byte;
    logic               unused_rand;

    assign cand_x      = rand_in[15:0] & x_mask;
    assign cand_y      = rand_in[31:16] & y_mask;
    assign bias_byte   = rand_in[39:32];
    assign unused_rand = ^rand_in[63:40];

    always_comb begin
        state_d = state_q;
        pt_d    = pt_q;
        goal_d  = goal_q;
        rej_d   = rej_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = DRAW;
            end
            DRAW: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (bias_byte < goal_bias) begin
                    pt_d    = '{x: goal_x, y: goal_y};
                    goal_d  = 1'b1;
                    state_d = HOLD;
                end else if (cand_x <= x_max && cand_y <= y_max) begin
                    pt_d    = '{x: cand_x, y: cand_y};
                    goal_d  = 1'b0;
                    state_d = HOLD;
                end else if (rej_q != 16'hFFFF) begin
                    rej_d = rej_q + 16'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = enable ? DRAW : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clearing wins over any increment decided in the same cycle.
        if (clear_stats) begin
            rej_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pt_q    <= '0;
            goal_q  <= 1'b0;
            rej_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            goal_q  <= goal_d;
            rej_q   <= rej_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rand_en      = rst_n && (state_q == DRAW) && enable;
    assign out_valid    = (state_q == HOLD);
    assign out_x        = pt_q.x;
    assign out_y        = pt_q.y;
    assign out_is_goal  = goal_q;
    assign reject_count = rej_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_rrt_sampler.sv
// Scoreboard bench for rrt_sampler: a cycle-level reference model predicts samples and counters,
// a separate monitor pops predicted samples on each output handshake.
module tb_rrt_sampler;

    logic        clk = 1'b0;
    logic        rst_n, enable, rand_en, out_valid, out_ready, out_is_goal, clear_stats;
    logic [63:0] rand_in;
    logic [15:0] x_max, y_max, x_mask, y_mask, goal_x, goal_y, out_x, out_y, reject_count;
    logic [7:0]  goal_bias;
    logic [31:0] sample_count;

    always #5 clk = ~clk;

    rrt_sampler #(.COORD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rand_in(rand_in), .rand_en(rand_en),
        .x_max(x_max), .y_max(y_max), .x_mask(x_mask), .y_mask(y_mask),
        .goal_x(goal_x), .goal_y(goal_y), .goal_bias(goal_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_is_goal(out_is_goal), .clear_stats(clear_stats),
        .reject_count(reject_count), .sample_count(sample_count)
    );

    typedef struct {
        int unsigned x;
        int unsigned y;
        bit          g;
    } samp_t;

    samp_t       sq[$];
    int          errors = 0;
    int          checks = 0;
    int          m_st = 0;     // 0 = idle, 1 = drawing, 2 = holding a sample
    int unsigned m_rej = 0;
    int unsigned m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against the model, advance the model, return after posedge.
    task automatic step(input bit en, input logic [63:0] rin, input bit rdy, input bit clr,
                        input bit rst = 1'b1);
        int unsigned cx, cy, bias;
        bit          rej_inc, cnt_inc;
        @(negedge clk);
        enable = en; rand_in = rin; out_ready = rdy; clear_stats = clr; rst_n = rst;
        #1;
        chk("rand_en", {63'd0, rand_en}, {63'd0, rst && m_st == 1 && en});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_st == 2});
        chk("reject_count", {48'd0, reject_count}, 64'(m_rej));
        chk("sample_count", {32'd0, sample_count}, 64'(m_cnt));
        rej_inc = 0;
        cnt_inc = 0;
        if (!rst) begin
            sq.delete();
            m_st = 0; m_rej = 0; m_cnt = 0;
        end else begin
            case (m_st)
                0: if (en) m_st = 1;
                1: begin
                    if (!en) m_st = 0;
                    else begin
                        cx   = int'(rin % 65536) & int'(x_mask);
                        cy   = int'((rin / 65536) % 65536) & int'(y_mask);
                        bias = int'((rin / 64'h1_0000_0000) % 256);
                        if (bias < goal_bias) begin
                            sq.push_back('{x: goal_x, y: goal_y, g: 1'b1});
                            m_st = 2;
                        end else if (cx <= x_max && cy <= y_max) begin
                            sq.push_back('{x: cx, y: cy, g: 1'b0});
                            m_st = 2;
                        end else rej_inc = 1;
                    end
                end
                default: if (rdy) begin cnt_inc = 1; m_st = en ? 1 : 0; end
            endcase
            if (clr) begin
                m_rej = 0; m_cnt = 0;
            end else begin
                if (rej_inc && m_rej < 65535) m_rej++;
                if (cnt_inc) m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: independent of the driver, compares each handshaken sample with the queue head.
    initial begin
        samp_t s;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sq.size() == 0) chk("unexpected_sample", 64'd1, 64'd0);
                else begin
                    s = sq.pop_front();
                    chk("out_x", {48'd0, out_x}, 64'(s.x));
                    chk("out_y", {48'd0, out_y}, 64'(s.y));
                    chk("out_is_goal", {63'd0, out_is_goal}, {63'd0, s.g});
                end
            end
        end
    end

    task automatic cfg(input int xm, input int ym, input int xk, input int yk, input int gb);
        x_max = 16'(xm); y_max = 16'(ym); x_mask = 16'(xk); y_mask = 16'(yk);
        goal_bias = 8'(gb);
    endtask

    initial begin
        int k;
        rst_n = 0; enable = 0; rand_in = '0; out_ready = 0; clear_stats = 0;
        goal_x = 0; goal_y = 0;
        cfg(100, 100, 127, 127, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("reset_out_x", {48'd0, out_x}, 64'd0);
        chk("reset_out_y", {48'd0, out_y}, 64'd0);
        chk("reset_goal", {63'd0, out_is_goal}, 64'd0);

        // In-bounds sample, then a reject followed by an accept.
        step(1, 0, 0, 0);
        step(1, 64'h0000_0000_0032_0014, 0, 0);
        chk("d1_out_x", {48'd0, out_x}, 64'd20);
        chk("d1_out_y", {48'd0, out_y}, 64'd50);
        step(1, 0, 1, 0);
        step(1, 64'h0000_0000_0064_0070, 0, 0);
        step(1, 64'h0000_0000_0001_0001, 0, 0);
        chk("d2_out_x", {48'd0, out_x}, 64'd1);
        step(1, 0, 1, 0);

        // Goal selection and the bias boundary.
        goal_x = 7; goal_y = 9;
        cfg(100, 100, 127, 127, 128);
        step(1, 64'h0000_007F_FFFF_FFFF, 0, 0);
        chk("goal_sel", {63'd0, out_is_goal}, 64'd1);
        step(1, 0, 1, 0);
        step(1, 64'h0000_0080_0005_0003, 0, 0);
        chk("bias_edge", {63'd0, out_is_goal}, 64'd0);

        // Back-pressure: held sample must not follow rand_in or goal changes.
        for (int i = 0; i < 5; i++) begin
            goal_x = 16'(i + 30);
            step(1, {$urandom, $urandom}, 0, 0);
            chk("hold_x", {48'd0, out_x}, 64'd3);
            chk("hold_y", {48'd0, out_y}, 64'd5);
        end
        step(1, 0, 1, 0);

        // Saturation of the reject counter, then clear racing a reject.
        cfg(0, 0, 16'hFFFF, 16'hFFFF, 0);
        for (int i = 0; i < 70000; i++) step(1, 64'h1, 0, 0);
        chk("rej_sat", {48'd0, reject_count}, 64'hFFFF);
        step(1, 64'h1, 0, 1);
        chk("rej_clear", {48'd0, reject_count}, 64'd0);

        // Reset while holding discards the pending sample.
        cfg(100, 100, 127, 127, 0);
        step(1, 64'h0000_0000_0002_0002, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hold_x", {48'd0, out_x}, 64'd0);

        // Randomized traffic with varying configuration.
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                k = int'($urandom_range(16, 0));
                x_mask = 16'((32'd1 << k) - 1);
                y_mask = 16'((32'd1 << $urandom_range(16, 0)) - 1);
                x_max = 16'($urandom_range(32'(x_mask), 0));
                y_max = 16'($urandom_range(32'(y_mask), 0));
                case ($urandom_range(3, 0))
                    0: goal_bias = 0;
                    1: goal_bias = 255;
                    default: goal_bias = 8'($urandom);
                endcase
                goal_x = 16'($urandom); goal_y = 16'($urandom);
            end
            step($urandom_range(7, 0) != 0, {$urandom, $urandom}, 1'($urandom),
                 $urandom_range(150, 0) == 0, $urandom_range(300, 0) != 0);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("queue_drained", 64'(sq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rrt_sampler.md
RRT_SAMPLER -- requirements
Module: rrt_sampler

Interface
REQ-001 SHALL have parameter COORD_W, default 16, coordinate width in bits (fixed 16 in this revision; bit fields below assume it).
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports: enable  input  1  run request; rand_in  input  64  current PRNG word; rand_en  output  1  advance request to the upstream prng64 enable.
REQ-004 SHALL have ports: x_max, y_max  input  COORD_W  inclusive upper bounds; x_mask, y_mask  input  COORD_W  candidate masks (2^k-1 covering the bound).
REQ-005 SHALL have ports: goal_x, goal_y  input  COORD_W  goal point; goal_bias  input  8  goal probability numerator over 256.
REQ-006 SHALL have ports: out_valid  output  1; out_ready  input  1; out_x, out_y  output  COORD_W  sample; out_is_goal  output  1  sample is goal.
REQ-007 SHALL have ports: clear_stats  input  1; reject_count  output  16  saturating rejected-draw count; sample_count  output  32  wrapping accepted-sample count.

Function
REQ-008 SHALL implement FSM states IDLE, DRAW, HOLD.
REQ-009 IDLE: rand_en=0, out_valid=0; enable=1 -> DRAW next cycle.
REQ-010 DRAW: rand_en=1 every cycle; current rand_in evaluated combinationally and consumed (PRNG advances on same edge).
REQ-011 Field split: cand_x = rand_in[15:0] & x_mask; cand_y = rand_in[31:16] & y_mask; bias_byte = rand_in[39:32]; rand_in[63:40] unused.
REQ-012 Priority in DRAW: bias_byte < goal_bias -> register goal_x/goal_y, out_is_goal=1, -> HOLD; else cand_x<=x_max and cand_y<=y_max -> register candidate, out_is_goal=0, -> HOLD; else reject, stay DRAW.
REQ-013 goal_bias=0 SHALL never select goal; goal_bias=255 selects goal for all bias_byte<255.
REQ-014 DRAW with enable=0 SHALL go IDLE next cycle without evaluating rand_in; rand_en=0 that cycle.
REQ-015 HOLD: out_valid=1; out_x, out_y, out_is_goal stable until out_valid && out_ready; enable deassertion SHALL NOT drop out_valid.
REQ-016 HOLD handshake: enable=1 -> DRAW, else -> IDLE; rand_en=0 throughout HOLD.
REQ-017 Latency: accepted draw in cycle N -> out_valid=1 in cycle N+1; peak throughput one sample per 2 cycles.
REQ-018 sample_count SHALL increment by 1 per handshake, wrapping 2^32-1 -> 0.
REQ-019 reject_count SHALL increment per rejected draw, saturating at 16'hFFFF.
REQ-020 clear_stats SHALL zero both counters next edge and take priority over same-cycle increments.
REQ-021 Configuration inputs SHALL be sampled only in DRAW; changes while in HOLD SHALL NOT affect the held sample.

Reset
REQ-022 rst_n=0 at a rising edge SHALL force state IDLE, out_valid=0, out_x=0, out_y=0, out_is_goal=0, reject_count=0, sample_count=0.
REQ-023 rand_en SHALL be 0 during reset; reset mid-DRAW or mid-HOLD SHALL discard any pending sample.
REQ-024 First possible rand_en=1 SHALL be the cycle after reset release with enable=1 (IDLE->DRAW).

Structure
REQ-025 Package rrt_pkg SHALL hold COORD_W, the state enum (IDLE/DRAW/HOLD), and a point struct {x, y}.
REQ-026 No sub-module; single FSM with registered outputs; rand_en decoded from state and enable.

Verification
REQ-027 Bounds 100/100, masks 127/127, bias 0; rand_in=64'h0000_0000_0032_0014 in DRAW -> next cycle out_valid=1, out=(20,50), out_is_goal=0, reject_count=0.
REQ-028 Same config; rand_in=64'h0000_0000_0064_0070 -> rejected (112>100), stay DRAW, reject_count=1; then 64'h0000_0000_0001_0001 -> out=(1,1).
REQ-029 goal=(7,9), bias 128; rand_in=64'h0000_007F_FFFF_FFFF -> out=(7,9), out_is_goal=1; bias_byte 8'h80 with in-bounds candidate -> out_is_goal=0.
REQ-030 out_ready=0 for 5 cycles in HOLD while rand_in and goal_x change -> outputs unchanged, rand_en=0; out_ready=1 -> sample_count=1, back to DRAW.
REQ-031 Force 70000 rejects -> reject_count=16'hFFFF; clear_stats with a same-cycle reject -> 0.
REQ-032 rst_n=0 for one cycle while in HOLD -> next cycle out_valid=0, state IDLE, counters 0, rand_en=0.
